add_4b: RTL and testbench

- Registered 4-bit binary adder with carry-in and carry-out.
- Serves as the basic add datapath slice of the integer ALU.
- Computes a + b + cin as a ripple-carry chain of full-adder cells.
- Captures result, carry and status flags in output registers, one cycle after a valid input.

---
 rtl/add_4b.sv | 90 +++++++++
 tb/tb_add_4b.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/add_4b.sv
// ---------------------------------------------------------------------------
// add_4b : registered ripple-carry adder slice for the integer ALU.
//
// Computes {cout, out} = a + b + cin through a chain of full-adder cells.
// The sum, the carry-out and the status flags are captured in output
// registers one cycle after in_valid is seen.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operands valid this cycle
//   a, b       WIDTH-bit operands (unsigned or two's complement)
//   cin        carry-in
//   out        registered sum bits
//   cout       registered carry-out of the MSB
//   ovf        registered signed overflow
//   zero       registered, 1 when out == 0 (independent of cout)
//   out_valid  registered result valid
// ---------------------------------------------------------------------------
module add_4b #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             out_valid
);

  // Carry chain: c[0] is the carry-in, c[WIDTH] the carry-out.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;
  logic             zero_d;

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic             valid_q;

  // Ripple-carry full-adder cells and derived flags.
  always_comb begin
    carry    = '0;
    sum_d    = '0;
    carry[0] = cin;
    for (int i = 0; i < int'(WIDTH); i++) begin
      sum_d[i]     = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout_d = carry[WIDTH];
    // Signed overflow: carry into the sign bit differs from carry out of it.
    ovf_d  = carry[WIDTH] ^ carry[WIDTH-1];
    zero_d = (sum_d == '0);
  end

  // Result registers load only on a valid input; out_valid tracks in_valid
  // every cycle so the result is held (not cleared) across idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

  assign out       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_add_4b.sv
// ---------------------------------------------------------------------------
// tb_add_4b : self-checking bench for add_4b. Expected values come from an
// arithmetic reference model (integer add, signed range test).
// ---------------------------------------------------------------------------
module tb_add_4b;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       cin = 1'b0;
  logic [3:0] out;
  logic       cout;
  logic       ovf;
  logic       zero;
  logic       out_valid;

  int checks = 0;
  int failures = 0;

  // Reference model state (what the output registers should hold).
  logic [3:0] exp_out   = '0;
  logic       exp_cout  = 1'b0;
  logic       exp_ovf   = 1'b0;
  logic       exp_zero  = 1'b0;
  logic       exp_valid = 1'b0;

  add_4b #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out       (out),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out"},       8'(out),       8'(exp_out));
    chk({tag, ".cout"},      8'(cout),      8'(exp_cout));
    chk({tag, ".ovf"},       8'(ovf),       8'(exp_ovf));
    chk({tag, ".zero"},      8'(zero),      8'(exp_zero));
    chk({tag, ".out_valid"}, 8'(out_valid), 8'(exp_valid));
  endtask

  task automatic model_clear();
    exp_out = '0; exp_cout = 1'b0; exp_ovf = 1'b0; exp_zero = 1'b0; exp_valid = 1'b0;
  endtask

  // Plain arithmetic reference: unsigned total and signed range check.
  task automatic model_step(input logic [3:0] va, input logic [3:0] vb,
                            input logic vc, input logic vv);
    int total;
    int sa;
    int sb;
    int ssum;
    exp_valid = vv;
    if (vv) begin
      total = int'(va) + int'(vb) + int'(vc);
      sa    = (va >= 4'd8) ? int'(va) - 16 : int'(va);
      sb    = (vb >= 4'd8) ? int'(vb) - 16 : int'(vb);
      ssum  = sa + sb + int'(vc);
      exp_out  = 4'(total % 16);
      exp_cout = (total >= 16);
      exp_ovf  = (ssum > 7) || (ssum < -8);
      exp_zero = ((total % 16) == 0);
    end
  endtask

  // Drive operands between edges, clock once, then compare #1 after the edge.
  task automatic apply(input string tag, input logic [3:0] va, input logic [3:0] vb,
                       input logic vc, input logic vv);
    a = va; b = vb; cin = vc; in_valid = vv;
    @(posedge clk);
    #1;
    model_step(va, vb, vc, vv);
    check_all(tag);
  endtask

  initial begin
    // Reset held from time 0.
    @(posedge clk); #1;
    model_clear();
    check_all("reset_hold");
    rst = 1'b0;
    apply("post_reset_idle", 4'd9, 4'd9, 1'b1, 1'b0);

    // Basic add with carry-in.
    apply("add_1_1_c1", 4'd1, 4'd1, 1'b1, 1'b1);
    apply("add_1_1_c0", 4'd1, 4'd1, 1'b0, 1'b1);

    // Carry-out and wrap-around.
    apply("wrap_15_1_c0", 4'd15, 4'd1, 1'b0, 1'b1);
    apply("wrap_15_1_c1", 4'd15, 4'd1, 1'b1, 1'b1);
    apply("wrap_15_15_c1", 4'd15, 4'd15, 1'b1, 1'b1);

    // Signed overflow.
    apply("ovf_7_1", 4'd7, 4'd1, 1'b0, 1'b1);
    apply("ovf_8_8", 4'd8, 4'd8, 1'b0, 1'b1);

    // Hold: result stays while in_valid is low and operands wander.
    apply("hold_3_4", 4'd3, 4'd4, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++)
      apply("hold_idle", 4'($urandom), 4'($urandom), 1'($urandom), 1'b0);

    // Asynchronous reset between edges clears outputs before the next edge.
    apply("pre_async", 4'd5, 4'd6, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    model_clear();
    check_all("async_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    check_all("reset_release");
    apply("after_release_idle", 4'd2, 4'd2, 1'b0, 1'b0);

    // Exhaustive back-to-back sweep with a one-cycle reset in the middle.
    for (int i = 0; i < 512; i++) begin
      if (i == 300) begin
        a = 4'd15; b = 4'd15; cin = 1'b1; in_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        model_clear();
        check_all("sweep_reset");
        rst = 1'b0;
      end
      apply("sweep", 4'(i >> 5), 4'(i >> 1), 1'(i), 1'b1);
    end

    // Random mix of valid and idle cycles.
    for (int k = 0; k < 200; k++)
      apply("random", 4'($urandom), 4'($urandom), 1'($urandom),
            1'($urandom_range(0, 3) != 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
